fetch_pc_ctrl: RTL and testbench

Instruction-fetch PC controller in the IF stage, on the receiving end of the branch unit's redirect (`br_e`, `br_addr`). It holds the architectural fetch PC, issues in-order fetch requests to the instruction-memory port and buffers returned instructions toward decode. On a branch or jump redirect it flushes wrong-path state and restarts fetch at the target.

---
 rtl/fetch_pc_ctrl_pkg.sv | 18 +
 rtl/fetch_fifo2.sv | 44 ++++
 rtl/fetch_pc_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_pc_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared reset PC, fetch tag/entry types, FIFO depth and FSM states
package fetch_pc_ctrl_pkg;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam int FETCH_DEPTH = 2;
  typedef struct packed {
    logic [63:0] pc;
    logic        epoch;
  } fetch_tag_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;
`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic {RUN, HALT} fetch_state_t;
`else
  typedef enum logic {RUN} fetch_state_t;
`endif
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry FIFO with synchronous flush
// Ports: clk, rst (sync, active-high); i_flush empties the FIFO but a same-cycle
// i_push still lands; i_push/i_din write; i_pop pops the head (ignored when empty
// or flushing); o_dout is the head entry; o_cnt is the occupancy (0..2).
module fetch_fifo2
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_cnt
);
  logic [W-1:0] r_mem [FETCH_DEPTH];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_wp, w_rp, w_pop;
  logic [1:0]   w_cnt;
  always_comb begin
    w_wp  = i_flush ? 1'b0 : r_wp;
    w_rp  = i_flush ? 1'b0 : r_rp;
    w_cnt = i_flush ? 2'd0 : r_cnt;
    w_pop = i_pop && !i_flush && r_cnt != 2'd0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_mem <= '{default: '0};
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_mem[w_wp] <= i_din;
      r_wp  <= w_wp ^ i_push;
      r_rp  <= w_rp ^ w_pop;
      r_cnt <= w_cnt + {1'b0, i_push} - {1'b0, w_pop};
    end
  assign o_dout = r_mem[r_rp];
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage fetch PC controller with in-order requests, epoch-tagged responses and redirect flush
// Ports: clk, rst (sync, active-high); br_e/br_addr redirect from EX;
// if_req_valid/if_req_addr/if_req_ready fetch request; if_rsp_valid/if_rsp_data in-order response;
// id_valid/id_pc/id_inst/id_ready decode handoff; id_misalign only with FETCH_MISALIGN_CHK_EN,
// which also adds the HALT state entered on a misaligned redirect target.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        if_req_valid,
  output logic [63:0] if_req_addr,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        id_misalign
`endif
);
  fetch_state_t r_state, w_state_nxt;
  logic [63:0]  r_pc, w_pc_nxt, w_br_tgt;
  logic         r_epoch;
  logic [1:0]   r_stale, w_stale_nxt, w_outst, w_buf_cnt;
  logic [2:0]   w_occ;
  logic         w_req_fire, w_rsp_pop, w_buf_push, w_id_pop, w_mis;
  fetch_tag_t   w_tag, w_tag_din;
  fetch_ent_t   w_buf_din, w_buf_dout;
`ifdef FETCH_MISALIGN_CHK_EN
  assign w_mis       = br_e && br_addr[1:0] != 2'b00;
  assign w_br_tgt    = br_addr;
  assign id_misalign = id_valid && r_state == HALT;
`else
  assign w_mis       = 1'b0;
  assign w_br_tgt    = br_addr & ~64'h3;
`endif
  // An even number of redirects while a request is in flight restores the old
  // epoch; r_stale counts the in-flight requests issued before the latest
  // redirect so those responses still drop despite the epoch matching again.
  always_comb begin
    w_occ        = {1'b0, w_outst} + {1'b0, w_buf_cnt};
    if_req_valid = !rst && !br_e && r_state == RUN && w_occ < 3'(MAX_OUTST);
    w_req_fire   = if_req_valid && if_req_ready;
    w_rsp_pop    = if_rsp_valid && w_outst != 2'd0;
    w_buf_push   = w_mis || (w_rsp_pop && !br_e && r_stale == 2'd0 && w_tag.epoch == r_epoch);
    w_id_pop     = id_valid && id_ready;
    w_tag_din    = fetch_tag_t'{pc: r_pc, epoch: r_epoch};
    w_buf_din    = w_mis ? fetch_ent_t'{pc: br_addr, inst: 32'h0}
                         : fetch_ent_t'{pc: w_tag.pc, inst: if_rsp_data};
    w_pc_nxt     = br_e ? w_br_tgt : w_req_fire ? r_pc + 64'd4 : r_pc;
    w_stale_nxt  = br_e ? w_outst - {1'b0, w_rsp_pop}
                        : r_stale - {1'b0, w_rsp_pop && r_stale != 2'd0};
`ifdef FETCH_MISALIGN_CHK_EN
    w_state_nxt  = br_e ? (w_mis ? HALT : RUN) : r_state;
`else
    w_state_nxt  = RUN;
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_pc    <= RESET_PC;
      r_epoch <= 1'b0;
      r_stale <= 2'd0;
      r_state <= RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_epoch <= r_epoch ^ br_e;
      r_stale <= w_stale_nxt;
      r_state <= w_state_nxt;
    end
  fetch_fifo2 #(.W($bits(fetch_tag_t))) u_tag (
    .clk    (clk),
    .rst    (rst),
    .i_flush(1'b0),
    .i_push (w_req_fire),
    .i_din  (w_tag_din),
    .i_pop  (w_rsp_pop),
    .o_dout (w_tag),
    .o_cnt  (w_outst)
  );
  fetch_fifo2 #(.W($bits(fetch_ent_t))) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_flush(br_e),
    .i_push (w_buf_push),
    .i_din  (w_buf_din),
    .i_pop  (w_id_pop),
    .o_dout (w_buf_dout),
    .o_cnt  (w_buf_cnt)
  );
  assign if_req_addr = r_pc;
  assign id_valid    = w_buf_cnt != 2'd0;
  assign id_pc       = w_buf_dout.pc;
  assign id_inst     = w_buf_dout.inst;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: scoreboard bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;
  logic        clk = 1'b0;
  logic        rst, br_e, if_req_valid, if_req_ready, if_rsp_valid, id_valid, id_ready;
  logic [63:0] br_addr, if_req_addr, id_pc;
  logic [31:0] if_rsp_data, id_inst;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        id_misalign;
`endif
  int          n_chk = 0, n_fail = 0;
  logic [63:0] q_mem[$];
  bit          q_stale[$];
  logic [95:0] q_exp[$];
  always #5 clk = ~clk;
  fetch_pc_ctrl dut (
    .clk(clk), .rst(rst), .br_e(br_e), .br_addr(br_addr),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
`ifdef FETCH_MISALIGN_CHK_EN
    , .id_misalign(id_misalign)
`endif
  );
  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction
  task automatic set_rsp(input bit v);
    if (v && q_mem.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_underflow: response requested with 0 pending, required >= 1");
      v = 0;
    end
    if_rsp_valid = v;
    if_rsp_data  = 32'h0;
    if (v) if_rsp_data = mem_data(q_mem[0]);
  endtask
  task automatic tick();
    logic [95:0] e;
    logic [63:0] a;
    bit          s;
    #1;
    if (id_valid && id_ready && !br_e) begin
      n_chk++;
      if (q_exp.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected: got pc=%h inst=%h, required no entry", id_pc, id_inst);
      end else begin
        e = q_exp.pop_front();
        if ({id_pc, id_inst} !== e) begin
          n_fail++; $display("FAIL sb_decode: got pc=%h inst=%h, required pc=%h inst=%h", id_pc, id_inst, e[95:32], e[31:0]);
        end
`ifdef FETCH_MISALIGN_CHK_EN
        n_chk++;
        if (id_misalign !== (e[33:32] != 2'b00)) begin
          n_fail++; $display("FAIL sb_misalign: got %b for pc=%h", id_misalign, e[95:32]);
        end
`endif
      end
    end
    if (if_rsp_valid && q_mem.size() > 0) begin
      a = q_mem.pop_front();
      s = q_stale.pop_front();
      if (!s && !br_e) q_exp.push_back({a, mem_data(a)});
    end
    if (br_e) begin
      q_exp.delete();
      foreach (q_stale[i]) q_stale[i] = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
      if (br_addr[1:0] != 2'b00) q_exp.push_back({br_addr, 32'h0});
`endif
    end
    if (if_req_valid && if_req_ready) begin
      q_mem.push_back(if_req_addr);
      q_stale.push_back(1'b0);
    end
    if (rst) begin
      q_mem.delete(); q_stale.delete(); q_exp.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    if_req_ready = 0; id_ready = 1; br_e = 0;
    for (int i = 0; i < 20; i++) begin
      set_rsp(q_mem.size() > 0);
      tick();
      if (q_mem.size() == 0 && !id_valid) break;
    end
    set_rsp(0);
    #1;
    n_chk++;
    if (id_valid !== 1'b0 || q_exp.size() != 0) begin
      n_fail++; $display("FAIL drain: id_valid=%b left=%0d, required 0 and 0", id_valid, q_exp.size());
    end
  endtask
  task automatic test_reset();
    rst = 1; br_e = 0; br_addr = 64'h0; if_req_ready = 1; id_ready = 0;
    set_rsp(0);
    tick(); tick();
    #1;
    n_chk++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b required 0", if_req_valid); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b required 0", id_valid); end
    n_chk++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h required 0", id_pc); end
    n_chk++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL rst_id_inst: got %h required 0", id_inst); end
`ifdef FETCH_MISALIGN_CHK_EN
    n_chk++; if (id_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b required 0", id_misalign); end
`endif
    rst = 0;
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0000) begin
      n_fail++; $display("FAIL first_req: got v=%b a=%h required v=1 a=80000000", if_req_valid, if_req_addr);
    end
  endtask
  task automatic test_basic();
    set_rsp(0);
    tick();
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0004) begin
      n_fail++; $display("FAIL second_req: got v=%b a=%h required v=1 a=80000004", if_req_valid, if_req_addr);
    end
    set_rsp(1);
    #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_no_bypass: id_valid=%b required 0", id_valid); end
    tick();
    set_rsp(1);
    #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0000 || id_inst !== mem_data(64'h8000_0000)) begin
      n_fail++; $display("FAIL rsp_latency: got v=%b pc=%h inst=%h required v=1 pc=80000000 inst=%h", id_valid, id_pc, id_inst, mem_data(64'h8000_0000));
    end
    n_chk++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL occ_limit: if_req_valid=%b required 0", if_req_valid); end
    tick();
  endtask
  task automatic test_stall();
    set_rsp(0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (if_req_valid !== 1'b0 || id_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_%0d: req_v=%b id_v=%b required 0 and 1", i, if_req_valid, id_valid);
      end
      tick();
    end
    id_ready = 1; if_req_ready = 0;
    tick();
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0008) begin
      n_fail++; $display("FAIL stall_release: got v=%b a=%h required v=1 a=80000008", if_req_valid, if_req_addr);
    end
    drain();
  endtask
  task automatic test_redirect();
    if_req_ready = 1; id_ready = 1;
    set_rsp(0);
    tick(); tick();
    br_e = 1; br_addr = 64'h8000_0100;
    #1;
    n_chk++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gate: got %b required 0", if_req_valid); end
    tick();
    br_e = 0; if_req_ready = 0;
    set_rsp(1);
    #1;
    n_chk++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_outst: got %b required 0", if_req_valid); end
    tick();
    set_rsp(1);
    #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop1: id_valid=%b required 0", id_valid); end
    tick();
    set_rsp(0);
    #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop2: id_valid=%b required 0", id_valid); end
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0100) begin
      n_fail++; $display("FAIL redir_target: got v=%b a=%h required v=1 a=80000100", if_req_valid, if_req_addr);
    end
  endtask
  task automatic test_same_cycle();
    if_req_ready = 1; id_ready = 0;
    tick();
    set_rsp(1);
    tick();
    #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0100) begin
      n_fail++; $display("FAIL same_pre: got v=%b pc=%h required v=1 pc=80000100", id_valid, id_pc);
    end
    br_e = 1; br_addr = 64'h8000_0200; id_ready = 1;
    set_rsp(1);
    tick();
    br_e = 0;
    set_rsp(0);
    #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL same_flush: id_valid=%b required 0", id_valid); end
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0200) begin
      n_fail++; $display("FAIL same_target: got v=%b a=%h required v=1 a=80000200", if_req_valid, if_req_addr);
    end
  endtask
  task automatic test_back_to_back();
    if_req_ready = 1; id_ready = 1;
    tick();
    br_e = 1; br_addr = 64'h100;
    #1;
    n_chk++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gate1: got %b required 0", if_req_valid); end
    tick();
    br_addr = 64'h200;
    #1;
    n_chk++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gate2: got %b required 0", if_req_valid); end
    tick();
    br_e = 0; if_req_ready = 0;
    set_rsp(1);
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h200) begin
      n_fail++; $display("FAIL b2b_target: got v=%b a=%h required v=1 a=200", if_req_valid, if_req_addr);
    end
    tick();
    set_rsp(0);
    #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: id_valid=%b required 0", id_valid); end
    if_req_ready = 1;
    tick();
    drain();
  endtask
`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    id_ready = 0; if_req_ready = 1;
    br_e = 1; br_addr = 64'h8000_0102;
    tick();
    br_e = 0;
    #1;
    n_chk++; if (id_valid !== 1'b1 || id_misalign !== 1'b1 || id_pc !== 64'h8000_0102 || id_inst !== 32'h0) begin
      n_fail++; $display("FAIL mis_entry: got v=%b m=%b pc=%h inst=%h required 1 1 80000102 0", id_valid, id_misalign, id_pc, id_inst);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (if_req_valid !== 1'b0 || id_valid !== 1'b1) begin
        n_fail++; $display("FAIL mis_halt_%0d: req_v=%b id_v=%b required 0 and 1", i, if_req_valid, id_valid);
      end
      tick();
      #1;
    end
    id_ready = 1;
    tick();
    #1;
    n_chk++; if (id_valid !== 1'b0 || if_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mis_consumed: id_v=%b req_v=%b required 0 and 0", id_valid, if_req_valid);
    end
    br_e = 1; br_addr = 64'h8000_0200;
    tick();
    br_e = 0;
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0200) begin
      n_fail++; $display("FAIL mis_exit: got v=%b a=%h required v=1 a=80000200", if_req_valid, if_req_addr);
    end
    drain();
  endtask
`else
  task automatic test_align();
    br_e = 1; br_addr = 64'h8000_0302;
    tick();
    br_e = 0;
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0300) begin
      n_fail++; $display("FAIL align_force: got v=%b a=%h required v=1 a=80000300", if_req_valid, if_req_addr);
    end
  endtask
`endif
  task automatic test_wrap();
    br_e = 1; br_addr = 64'hFFFF_FFFF_FFFF_FFFC; if_req_ready = 1;
    tick();
    br_e = 0;
    #1;
    n_chk++; if (if_req_valid !== 1'b1 || if_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_start: got v=%b a=%h required v=1 a=fffffffffffffffc", if_req_valid, if_req_addr);
    end
    tick();
    if_req_ready = 0;
    #1;
    n_chk++; if (if_req_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_pc: got %h required 0", if_req_addr); end
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_same_cycle();
    test_back_to_back();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`else
    test_align();
`endif
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
